// File: rtl/synth_drv_pkg.sv
// Shared types and helpers for the synth core stimulus driver.
// The LFSR and the MISR use the same Galois step function.
package synth_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } drv_state_t;

  localparam logic [31:0] POLY_DEFAULT = 32'h8020_0003;
  localparam int          MAX_LATENCY  = 4;

  function automatic logic [31:0] lfsr_step(input logic [31:0] value,
                                            input logic [31:0] poly);
    return {value[30:0], 1'b0} ^ (value[31] ? poly : 32'h0000_0000);
  endfunction

  function automatic logic [31:0] bit_reverse(input logic [31:0] value);
    logic [31:0] rev;
    rev = '0;
    for (int i = 0; i < 32; i++) begin
      rev[i] = value[31-i];
    end
    return rev;
  endfunction

endpackage

// File: rtl/synth_drv_lfsr.sv
// Loadable 32-bit Galois LFSR; a zero seed is replaced by 1 so the
// generator never locks up in the all-zero state.
module synth_drv_lfsr
  import synth_drv_pkg::*;
#(
  parameter logic [31:0] POLY = POLY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        enable,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;
    end else if (enable) begin
      value <= lfsr_step(value, POLY);
    end
  end

endmodule

// File: rtl/synth_core_driver.sv
// Drives pseudo-random operand vectors into a synth core and compacts
// the returned results into a MISR signature.
module synth_core_driver
  import synth_drv_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int          LATENCY = 1,
  parameter logic [31:0] POLY    = POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      num_vec,
  input  logic [31:0]      seed,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  output logic [WIDTH-1:0] core_c,
  output logic             core_sel,
  input  logic [WIDTH-1:0] core_result,
  output logic             busy,
  output logic             done,
  output logic [15:0]      vec_count,
  output logic [31:0]      signature
);

  localparam int                CNT_W      = $clog2(MAX_LATENCY);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(LATENCY - 1);

  drv_state_t         state_q;
  drv_state_t         state_d;
  logic               accept;
  logic               issue;
  logic [31:0]        lfsr_value;
  logic [15:0]        num_vec_q;
  logic [31:0]        sig_q;
  logic [CNT_W-1:0]   drain_cnt;
  logic [LATENCY-1:0] valid_pipe;
  logic [LATENCY-1:0] valid_next;
  logic               capture;

  synth_drv_lfsr #(
    .POLY(POLY)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .enable(issue),
    .seed  (seed),
    .value (lfsr_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A zero-length run skips straight to DONE so done still pulses at T+1.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (num_vec == 16'd0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        issue = 1'b1;
        busy  = 1'b1;
        if (vec_count == num_vec_q - 16'd1) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  generate
    if (LATENCY == 1) begin : g_pipe_single
      assign valid_next = issue;
    end else begin : g_pipe_multi
      assign valid_next = {valid_pipe[LATENCY-2:0], issue};
    end
  endgenerate

  assign capture = valid_pipe[LATENCY-1];

  // The tail of the valid pipe marks the cycle a vector's result is on core_result.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_count  <= '0;
      num_vec_q  <= '0;
      sig_q      <= '0;
      drain_cnt  <= '0;
      valid_pipe <= '0;
    end else begin
      valid_pipe <= valid_next;
      drain_cnt  <= (state_q == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
      if (accept) begin
        vec_count <= '0;
        num_vec_q <= num_vec;
        sig_q     <= '0;
      end else begin
        if (issue && (vec_count != num_vec_q)) begin
          vec_count <= vec_count + 16'd1;
        end
        if (capture) begin
          sig_q <= lfsr_step(sig_q, POLY) ^ core_result;
        end
      end
    end
  end

  always_comb begin
    core_a   = '0;
    core_b   = '0;
    core_c   = '0;
    core_sel = 1'b0;
    if (issue) begin
      core_a   = lfsr_value;
      core_b   = bit_reverse(lfsr_value);
      core_c   = ~lfsr_value;
      core_sel = lfsr_value[0];
    end
  end

  assign signature = sig_q;

endmodule

// File: tb/tb_synth_core_driver.sv
// Randomized self-checking bench: a cycle-offset reference model predicts every
// driver output from the run parameters, plus a few hand-computed anchors.
module tb_synth_core_driver;

  localparam int          LAT  = 1;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vec;
  logic [31:0] seed;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic [31:0] core_c;
  logic        core_sel;
  logic [31:0] core_result;
  logic        busy;
  logic        done;
  logic [15:0] vec_count;
  logic [31:0] signature;

  int n_checks = 0;
  int n_fail   = 0;
  int core_mode = 0;

  int          cyc = 0;
  bit          model_valid = 0;
  bit          have_run = 0;
  int          run_t = 0;
  int          run_n = 0;
  logic [31:0] exp_vec[$];
  logic [31:0] exp_sig[$];

  always #5 clk = ~clk;

  synth_core_driver #(
    .WIDTH  (32),
    .LATENCY(LAT),
    .POLY   (POLY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_vec    (num_vec),
    .seed       (seed),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_c     (core_c),
    .core_sel   (core_sel),
    .core_result(core_result),
    .busy       (busy),
    .done       (done),
    .vec_count  (vec_count),
    .signature  (signature)
  );

  function automatic logic [31:0] tb_step(input logic [31:0] v);
    logic [31:0] r;
    r = v * 32'd2;
    if (v >= 32'h8000_0000) r = r ^ POLY;
    return r;
  endfunction

  function automatic logic [31:0] tb_rev(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[31-i] = v[i];
    return r;
  endfunction

  // Mode 0: loopback of core_a. Mode 1: a synth_core_4-like mixing function.
  function automatic logic [31:0] core_fn(input int mode, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c,
                                          input logic sel);
    if (mode == 0) return a;
    return sel ? ((a + b) ^ c) : (((a & b) | {c[15:0], c[31:16]}) + 32'h1234_5678);
  endfunction

  always @(posedge clk) begin
    if (rst) core_result <= '0;
    else     core_result <= core_fn(core_mode, core_a, core_b, core_c, core_sel);
  end

  function automatic int done_off();
    return (run_n == 0) ? 1 : run_n + LAT + 1;
  endfunction

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic build_run(input logic [31:0] s, input int n, input int mode);
    logic [31:0] v;
    logic [31:0] sg;
    exp_vec.delete();
    exp_sig.delete();
    v  = (s == 0) ? 32'd1 : s;
    sg = 32'd0;
    exp_sig.push_back(sg);
    for (int k = 0; k < n; k++) begin
      exp_vec.push_back(v);
      sg = tb_step(sg) ^ core_fn(mode, v, tb_rev(v), ~v, v[0]);
      exp_sig.push_back(sg);
      v = tb_step(v);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: tracks accepted starts and resets at each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        model_valid = 1;
        have_run    = 0;
      end else if (model_valid && start && (!have_run || (cyc - run_t) > done_off())) begin
        have_run = 1;
        run_t    = cyc;
        run_n    = int'(num_vec);
        build_run(seed, run_n, core_mode);
      end
      cyc++;
    end
  end

  // Compare process: every output checked on every cycle after the first reset.
  initial begin
    int          off;
    int          m;
    bit          in_run;
    logic [31:0] v;
    forever begin
      @(negedge clk);
      if (model_valid) begin
        if (!have_run) begin
          checkOutput("core_a", core_a, 32'd0);
          checkOutput("core_b", core_b, 32'd0);
          checkOutput("core_c", core_c, 32'd0);
          checkOutput("core_sel", {31'd0, core_sel}, 32'd0);
          checkOutput("busy", {31'd0, busy}, 32'd0);
          checkOutput("done", {31'd0, done}, 32'd0);
          checkOutput("vec_count", {16'd0, vec_count}, 32'd0);
          checkOutput("signature", signature, 32'd0);
        end else begin
          off    = cyc - run_t;
          in_run = (off >= 1) && (off <= run_n);
          v      = in_run ? exp_vec[off-1] : 32'd0;
          m      = (run_n == 0) ? 0 : clamp(off - 1 - LAT, run_n);
          checkOutput("core_a", core_a, v);
          checkOutput("core_b", core_b, in_run ? tb_rev(v) : 32'd0);
          checkOutput("core_c", core_c, in_run ? ~v : 32'd0);
          checkOutput("core_sel", {31'd0, core_sel}, {31'd0, in_run & v[0]});
          checkOutput("busy", {31'd0, busy}, {31'd0, (off >= 1) && (off <= run_n + LAT) && (run_n > 0)});
          checkOutput("done", {31'd0, done}, {31'd0, off == done_off()});
          checkOutput("vec_count", {16'd0, vec_count}, 32'(clamp(off - 1, run_n)));
          checkOutput("signature", signature, exp_sig[m]);
        end
      end
    end
  end

  task automatic syncEdge();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 into the first RUN cycle.
  task automatic applyStimulus(input logic [31:0] s, input logic [15:0] n);
    start   = 1'b1;
    num_vec = n;
    seed    = s;
    syncEdge();
    start   = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (done === 1'b1) found = 1;
    end
    checkOutput("done_within_budget", {31'd0, found}, 32'd1);
    syncEdge();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rs;
    int          rn;
    rst     = 1'b1;
    start   = 1'b0;
    num_vec = '0;
    seed    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("lit_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("lit_reset_sig", signature, 32'd0);
    syncEdge();

    // Loopback, seed 1, one vector.
    core_mode = 0;
    applyStimulus(32'd1, 16'd1);
    @(negedge clk);
    checkOutput("lit_v0_a", core_a, 32'h0000_0001);
    checkOutput("lit_v0_b", core_b, 32'h8000_0000);
    checkOutput("lit_v0_c", core_c, 32'hFFFF_FFFE);
    checkOutput("lit_v0_sel", {31'd0, core_sel}, 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("lit_n1_done", {31'd0, done}, 32'd1);
    checkOutput("lit_n1_sig", signature, 32'h0000_0001);
    checkOutput("lit_n1_count", {16'd0, vec_count}, 32'd1);
    syncEdge();

    // Loopback, two vectors, started with the minimum gap.
    applyStimulus(32'd1, 16'd2);
    repeat (2) @(negedge clk);
    checkOutput("lit_v1_a", core_a, 32'h0000_0002);
    repeat (2) @(negedge clk);
    checkOutput("lit_n2_done", {31'd0, done}, 32'd1);
    checkOutput("lit_n2_sig", signature, 32'h0000_0000);
    checkOutput("lit_n2_count", {16'd0, vec_count}, 32'd2);
    syncEdge();

    // Seed 0 and seed 1 against the mixing core.
    core_mode = 1;
    applyStimulus(32'd1, 16'd100);
    waitDone(100 + LAT + 5);
    applyStimulus(32'd0, 16'd100);
    waitDone(100 + LAT + 5);

    // Zero-length run.
    applyStimulus(32'd5, 16'd0);
    @(negedge clk);
    checkOutput("lit_n0_done", {31'd0, done}, 32'd1);
    checkOutput("lit_n0_busy", {31'd0, busy}, 32'd0);
    checkOutput("lit_n0_core_a", core_a, 32'd0);
    checkOutput("lit_n0_sig", signature, 32'd0);
    syncEdge();
    @(negedge clk);
    checkOutput("lit_n0_done_after", {31'd0, done}, 32'd0);
    syncEdge();

    // Start pulses mid-run and in the done cycle are ignored.
    applyStimulus(32'h0000_CAFE, 16'd40);
    repeat (10) syncEdge();
    start = 1'b1; num_vec = 16'd7; seed = 32'h1357_9BDF;
    syncEdge();
    start = 1'b0;
    repeat (40 + LAT + 1 - 12) syncEdge();
    start = 1'b1;
    @(negedge clk);
    checkOutput("lit_ign_done", {31'd0, done}, 32'd1);
    syncEdge();
    start = 1'b0;
    @(negedge clk);
    checkOutput("lit_ign_busy", {31'd0, busy}, 32'd0);
    checkOutput("lit_ign_count", {16'd0, vec_count}, 32'd40);
    syncEdge();

    // Reset at vector 50 of 100, then a fresh full run.
    applyStimulus(32'hA5A5_0F0F, 16'd100);
    repeat (50) syncEdge();
    rst = 1'b1;
    syncEdge();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("lit_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("lit_rst_core_a", core_a, 32'd0);
    checkOutput("lit_rst_count", {16'd0, vec_count}, 32'd0);
    checkOutput("lit_rst_sig", signature, 32'd0);
    syncEdge();
    applyStimulus(32'hA5A5_0F0F, 16'd100);
    waitDone(100 + LAT + 5);

    // Randomized runs with stray start pulses.
    for (int it = 0; it < 10; it++) begin
      core_mode = int'($urandom_range(0, 1));
      rs = $urandom;
      rn = (it == 3) ? 0 : int'($urandom_range(1, 60));
      repeat ($urandom_range(0, 2)) syncEdge();
      applyStimulus(rs, 16'(rn));
      if (rn > 2) begin
        repeat ($urandom_range(0, rn - 2)) syncEdge();
        start = 1'b1; num_vec = 16'($urandom); seed = $urandom;
        syncEdge();
        start = 1'b0;
      end
      waitDone(rn + LAT + 5);
    end

    repeat (3) syncEdge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
